// File: rtl/decode_scan.sv
// decode_scan: registered one-cold (active-low) decoder with an auto-scan mode.
//
// Direct mode (scan=0) decodes sel with one cycle of latency. Scan mode
// (scan=1) walks idx through 0..N-1, holding each index for DWELL cycles,
// and pulses wrap for one cycle after idx rolls over from N-1 to 0.
// enable=1 blanks Y and freezes idx and the dwell counter.
//
// Build option:
//   DECODE_SCAN_BLANK_EN - break-before-make in scan mode. Y is all ones for
//                          the first cycle of every new dwell; that cycle is
//                          part of the dwell.
//
// Parameters:
//   SEL_W  - select width (1..4); N = 2**SEL_W outputs
//   DWELL  - cycles per index in scan mode (1..255)
//
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset
//   sel    - direct-mode select (ignored in scan mode)
//   enable - 1 blanks Y and freezes idx/dwell; 0 allows decode
//   scan   - 0 direct decode, 1 auto-scan
//   Y      - registered one-cold outputs, Y[k] low when idx == k
//   idx    - registered current index
//   wrap   - registered one-cycle pulse after a scan roll-over
module decode_scan #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    enable,
  input  logic                    scan,
  output logic [0:(2**SEL_W)-1]   Y,
  output logic [SEL_W-1:0]        idx,
  output logic                    wrap
);

  localparam int N      = 2**SEL_W;
  localparam int DCNT_W = 8;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]  IDX_LAST  = SEL_W'(N - 1);

`ifdef DECODE_SCAN_BLANK_EN
  localparam bit BLANK_STEP = 1'b1;
`else
  localparam bit BLANK_STEP = 1'b0;
`endif

  typedef logic [0:N-1] y_t;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

  function automatic y_t decode_cold(input logic [SEL_W-1:0] i);
    y_t r;
    for (int k = 0; k < N; k++) begin
      r[k] = (i != SEL_W'(k));
    end
    return r;
  endfunction

  mode_t              mode_p0, mode_d;
  y_t                 y_p0, y_d;
  logic [SEL_W-1:0]   idx_p0, idx_d;
  logic [DCNT_W-1:0]  dcnt_p0, dcnt_d;
  logic               wrap_p0, wrap_d;
  logic [SEL_W-1:0]   idx_step;

  assign idx_step = idx_p0 + 1'b1;

  always_comb begin
    mode_d = scan ? MODE_SCAN : MODE_DIRECT;
    y_d    = '1;
    idx_d  = idx_p0;
    dcnt_d = dcnt_p0;
    wrap_d = 1'b0;

    if (enable) begin
      // blanked: Y inactive, idx and dwell frozen, wrap suppressed
      y_d = '1;
    end else if (!scan) begin
      // direct decode; also the scan-exit edge, which reloads from sel
      idx_d  = sel;
      dcnt_d = '0;
      y_d    = decode_cold(sel);
    end else if (mode_p0 == MODE_DIRECT) begin
      // scan entry: restart the dwell at the current index without stepping
      dcnt_d = '0;
      y_d    = decode_cold(idx_p0);
    end else if (dcnt_p0 >= DCNT_LAST) begin
      idx_d  = idx_step;
      dcnt_d = '0;
      wrap_d = (idx_p0 == IDX_LAST);
      y_d    = BLANK_STEP ? y_t'('1) : decode_cold(idx_step);
    end else begin
      dcnt_d = dcnt_p0 + 1'b1;
      y_d    = decode_cold(idx_p0);
    end
  end

  // ---- register stage p0 ----
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_p0 <= MODE_DIRECT;
      y_p0    <= '1;
      idx_p0  <= '0;
      dcnt_p0 <= '0;
      wrap_p0 <= 1'b0;
    end else begin
      mode_p0 <= mode_d;
      y_p0    <= y_d;
      idx_p0  <= idx_d;
      dcnt_p0 <= dcnt_d;
      wrap_p0 <= wrap_d;
    end
  end

  assign Y    = y_p0;
  assign idx  = idx_p0;
  assign wrap = wrap_p0;

endmodule

// File: tb/tb_decode_scan.sv
// Directed bench for decode_scan with SEL_W=2, DWELL=3. Expected scan-mode Y
// values follow the DECODE_SCAN_BLANK_EN setting of the build.
module tb_decode_scan;

  localparam int SEL_W = 2;
  localparam int DWELL = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [SEL_W-1:0] sel;
  logic             enable;
  logic             scan;
  logic [0:3]       Y;
  logic [SEL_W-1:0] idx;
  logic             wrap;
  logic [3:0]       y_v;

  int n_checks = 0;
  int n_errors = 0;

`ifdef DECODE_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  decode_scan #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .enable (enable),
    .scan   (scan),
    .Y      (Y),
    .idx    (idx),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  // Y[0] lands in the MSB so values read left to right as Y[0..3]
  assign y_v = Y;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] ey,
                            input logic [1:0] ei, input logic ew);
    check({tag, ".Y"},    8'(y_v),  8'(ey));
    check({tag, ".idx"},  8'(idx),  8'(ei));
    check({tag, ".wrap"}, 8'(wrap), 8'(ew));
  endtask

  function automatic logic [3:0] dec(input logic [1:0] i);
    logic [3:0] r;
    r = 4'b1111;
    r[3 - i] = 1'b0;
    return r;
  endfunction

  // idx after each edge from scan entry (E0) to the roll-over edge (E12)
  logic [1:0] scan_idx [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  initial begin
    reset = 1'b1; enable = 1'b0; scan = 1'b0; sel = 2'd2;

    // reset held two cycles
    tick(); expect_out("rst1", 4'b1111, 2'd0, 1'b0);
    tick(); expect_out("rst2", 4'b1111, 2'd0, 1'b0);

    // first edge after release decodes sel=2
    reset = 1'b0;
    tick(); expect_out("rel", 4'b1101, 2'd2, 1'b0);

    // direct mode, one cycle latency
    sel = 2'd0; tick(); expect_out("dir0", 4'b0111, 2'd0, 1'b0);
    sel = 2'd1; tick(); expect_out("dir1", 4'b1011, 2'd1, 1'b0);
    sel = 2'd2; tick(); expect_out("dir2", 4'b1101, 2'd2, 1'b0);
    sel = 2'd3; tick(); expect_out("dir3", 4'b1110, 2'd3, 1'b0);

    // park at idx=0, then scan with sel set to something that must be ignored
    sel = 2'd0; tick(); expect_out("park", 4'b0111, 2'd0, 1'b0);
    scan = 1'b1; sel = 2'd3;
    for (int e = 0; e < 13; e++) begin
      logic [3:0] ey;
      tick();
      ey = (BLANK && e > 0 && (e % 3) == 0) ? 4'b1111 : dec(scan_idx[e]);
      expect_out($sformatf("scan_e%0d", e), ey, scan_idx[e], (e == 12));
    end
    // dwell counter now 1 at idx 0
    tick(); expect_out("scan_d1", 4'b0111, 2'd0, 1'b0);

    // blank for five cycles mid-dwell
    enable = 1'b1;
    for (int b = 0; b < 5; b++) begin
      tick(); expect_out($sformatf("blank%0d", b), 4'b1111, 2'd0, 1'b0);
    end
    enable = 1'b0;
    tick(); expect_out("resume1", 4'b0111, 2'd0, 1'b0);
    tick(); expect_out("resume2", BLANK ? 4'b1111 : 4'b1011, 2'd1, 1'b0);

    // advance to idx=3, dcnt=2
    for (int s = 0; s < 8; s++) tick();
    expect_out("pre_rst", 4'b1110, 2'd3, 1'b0);

    // reset mid-scan: no wrap pulse
    reset = 1'b1;
    tick(); expect_out("rst_scan", 4'b1111, 2'd0, 1'b0);
    reset = 1'b0;
    tick(); expect_out("scan_entry", 4'b0111, 2'd0, 1'b0);
    tick(); expect_out("scan_e1b", 4'b0111, 2'd0, 1'b0);

    // leave scan: idx loads sel on that edge
    scan = 1'b0; sel = 2'd1;
    tick(); expect_out("scan_exit", 4'b1011, 2'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
